// File: rtl/ps2_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ps2_pkg : shared PS/2 state encoding, command codes and parity helper
// Revision: 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // PS/2 frames carry odd parity over the 8 data bits
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ps2_sync_edge : 2-flop synchroniser with falling-edge detect for a PS/2 line
// Revision: 1.0
// ============================================================================
module ps2_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a false edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign fall  = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ps2_host_tx : PS/2 host-to-device command transmitter (open-drain enables)
// Revision: 1.0
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_level;
    logic w_clk_fall;
    logic w_dat_level;
    logic w_dat_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .din    (PS2_KBCLK),
        .level  (w_clk_level),
        .fall   (w_clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .din    (PS2_KBDAT),
        .level  (w_dat_level),
        .fall   (w_dat_fall_unused)
    );

    ps2_tx_state_t    r_state,   w_state_nxt;
    logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_nxt;
    logic [TO_W-1:0]  r_to_cnt,  w_to_cnt_nxt;
    logic [3:0]       r_bitcnt,  w_bitcnt_nxt;
    logic [7:0]       r_shift,   w_shift_nxt;
    logic             r_par,     w_par_nxt;
    logic             r_ok,      w_ok_nxt;
    logic             r_dat_oe,  w_dat_oe_nxt;
    logic             r_done,    w_done_nxt;
    logic             r_err,     w_err_nxt;
    logic             w_active;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_ok      <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_inh_cnt <= w_inh_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
            r_ok      <= w_ok_nxt;
            r_dat_oe  <= w_dat_oe_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign w_active = (r_state == REQ) || (r_state == SEND) ||
                      (r_state == ACK) || (r_state == WAIT_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_inh_cnt_nxt = r_inh_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_par_nxt     = r_par;
        w_ok_nxt      = r_ok;
        w_dat_oe_nxt  = r_dat_oe;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                w_dat_oe_nxt  = 1'b0;
                w_inh_cnt_nxt = '0;
                w_to_cnt_nxt  = '0;
                if (tx_valid) begin
                    w_shift_nxt = tx_data;
                    w_par_nxt   = odd_parity(tx_data);
                    w_state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                if (r_inh_cnt == INH_LAST) begin
                    w_state_nxt  = REQ;
                    w_to_cnt_nxt = '0;
                    w_bitcnt_nxt = '0;
                    w_dat_oe_nxt = 1'b1;
                end else begin
                    w_inh_cnt_nxt = r_inh_cnt + INH_W'(1);
                end
            end
            REQ: begin
                w_state_nxt = SEND;
            end
            SEND: begin
                // Device clocks the line; the next bit goes out on each falling edge
                if (w_clk_fall) begin
                    if (r_bitcnt < 4'd8) begin
                        w_dat_oe_nxt = ~r_shift[r_bitcnt[2:0]];
                    end else if (r_bitcnt == 4'd8) begin
                        w_dat_oe_nxt = ~r_par;
                    end else begin
                        w_dat_oe_nxt = 1'b0;
                        w_state_nxt  = ACK;
                    end
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                end
            end
            ACK: begin
                if (w_clk_fall) begin
                    w_ok_nxt    = ~w_dat_level;
                    w_state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_level && w_dat_level) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = r_ok;
                    w_err_nxt   = ~r_ok;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // One timeout budget spans the whole transaction from inhibit release
        if (w_active) begin
            if (r_to_cnt == TO_LAST) begin
                w_state_nxt  = IDLE;
                w_dat_oe_nxt = 1'b0;
                w_done_nxt   = 1'b0;
                w_err_nxt    = 1'b1;
            end else begin
                w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            end
        end
    end

    assign ps2_clk_oe = (r_state == INHIBIT) || (r_state == REQ);
    assign ps2_dat_oe = r_dat_oe;
    assign tx_ready   = (r_state == IDLE);
    assign busy       = ~tx_ready;
    assign tx_done    = r_done;
    assign tx_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_ps2_host_tx : directed bench with a simple PS/2 device model on the lines
// Revision: 1.0
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 6000;
    localparam int TOUT = 5000;
    localparam int HALF = 40;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       dev_clk_low;
    logic       dev_dat_low;
    logic       tx_valid;
    logic [7:0] tx_data;
    wire        PS2_KBCLK;
    wire        PS2_KBDAT;
    wire        ps2_clk_oe;
    wire        ps2_dat_oe;
    wire        tx_ready;
    wire        busy;
    wire        tx_done;
    wire        tx_err;

    int n_vec  = 0;
    int n_miss = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int long_cnt = 0;
    int hs_cnt   = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    // Wired-AND open-drain lines with pull-ups
    assign PS2_KBCLK = ~(ps2_clk_oe | dev_clk_low);
    assign PS2_KBDAT = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .PS2_KBCLK  (PS2_KBCLK),
        .PS2_KBDAT  (PS2_KBDAT),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
        if ((tx_done && prev_done) || (tx_err && prev_err)) long_cnt++;
        prev_done = tx_done;
        prev_err  = tx_err;
    end

    always @(posedge CLOCK_50) begin
        if (resetn && tx_valid && tx_ready) hs_cnt++;
    end

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Device drives n clock pulses; bit 0 is the start bit seen before the first pulse
    task automatic dev_clocks(input int n, output logic [10:0] bits);
        bits = '0;
        repeat (10) tick();
        bits[0] = PS2_KBDAT;
        for (int i = 1; i <= n; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
            repeat (HALF) tick();
            bits[i] = PS2_KBDAT;
        end
    endtask

    task automatic dev_ack(input bit ack);
        dev_dat_low = ack;
        repeat (HALF) tick();
        dev_clk_low = 1'b1;
        repeat (HALF) tick();
        dev_clk_low = 1'b0;
        repeat (HALF) tick();
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 100);
        check_val({tag, "_start"}, 32'(busy), 32'd1);
    endtask

    task automatic run_tx(input string tag, input logic [7:0] data, input bit ack,
                          input logic [10:0] exp_bits, input bit exp_ok, input bit hold);
        int d0, e0, inh, n;
        logic [10:0] got;
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = data;
        tx_valid = 1'b1;
        wait_busy(tag);
        if (!hold) tx_valid = 1'b0;
        inh = 0;
        while (ps2_clk_oe && !ps2_dat_oe && inh < 20000) begin
            inh++;
            tick();
        end
        check_val({tag, "_inhibit_len"}, 32'(inh), 32'(INH));
        check_val({tag, "_req_oe"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd3);
        tick();
        check_val({tag, "_send_oe"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
        dev_clocks(10, got);
        check_val({tag, "_bits"}, 32'(got), 32'(exp_bits));
        dev_ack(ack);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 1000) begin
            tick();
            n++;
        end
        check_val({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_ok));
        check_val({tag, "_err"}, 32'(err_cnt - e0), 32'(!exp_ok));
        check_val({tag, "_ready"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        int d0, e0, h0, n;
        logic [10:0] part;

        resetn      = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) tick();
        check_val("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check_val("rst_ready", {30'd0, tx_ready, busy}, 32'd2);
        check_val("rst_pulses", {30'd0, tx_done, tx_err}, 32'd0);
        resetn = 1'b1;
        repeat (5) tick();

        run_tx("leds",  CMD_SET_LEDS, 1'b1, 11'h7DA, 1'b1, 1'b0);
        run_tx("b01",   8'h01,        1'b1, 11'h402, 1'b1, 1'b0);
        run_tx("b00",   8'h00,        1'b1, 11'h600, 1'b1, 1'b0);
        run_tx("nack",  CMD_ECHO,     1'b0, 11'h7DC, 1'b0, 1'b0);

        // Silent device: transaction must time out
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = CMD_RESET;
        tx_valid = 1'b1;
        wait_busy("tout");
        tx_valid = 1'b0;
        n = 0;
        while (!ps2_dat_oe && n < 20000) begin
            tick();
            n++;
        end
        n = 0;
        while (!tx_err && n < 20000) begin
            tick();
            n++;
        end
        check_val("tout_latency", 32'(n), 32'(TOUT));
        check_val("tout_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check_val("tout_done", 32'(done_cnt - d0), 32'd0);
        check_val("tout_err", 32'(err_cnt - e0), 32'd1);
        repeat (5) tick();

        // Reset after four data bits have gone out
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        wait_busy("midrst");
        tx_valid = 1'b0;
        n = 0;
        while (!ps2_dat_oe && n < 20000) begin
            tick();
            n++;
        end
        dev_clocks(4, part);
        check_val("midrst_bits", 32'(part[4:0]), 32'h14);
        resetn = 1'b0;
        tick();
        check_val("midrst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check_val("midrst_ready", 32'(tx_ready), 32'd1);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (20) tick();
        check_val("midrst_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // tx_valid held through a transfer gives exactly two transfers
        h0 = hs_cnt;
        run_tx("b2b_1", CMD_RESET, 1'b1, 11'h7FE, 1'b1, 1'b1);
        run_tx("b2b_2", CMD_RESET, 1'b1, 11'h7FE, 1'b1, 1'b0);
        repeat (50) tick();
        check_val("b2b_count", 32'(hs_cnt - h0), 32'd2);

        check_val("pulse_overlap", 32'(both_cnt), 32'd0);
        check_val("pulse_width", 32'(long_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
